// File: rtl/mult_pkg.sv
// Shared state encoding and sign helper for the sequential shift-add multiplier.
package mult_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // The caller sign-extends value to MAX_WIDTH in signed mode, so bit 31 is the true sign.
  function automatic logic [MAX_WIDTH-1:0] abs_twos(input logic [MAX_WIDTH-1:0] value,
                                                    input logic                 signed_mode);
    if (signed_mode && value[MAX_WIDTH-1]) begin
      return ~value + MAX_WIDTH'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Parametrised shift-add multiplier: one partial product per clock, start/done handshake,
// optional two's-complement operands, registered result held between operations.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 r_busy;
  logic                 r_done;

  logic [MAX_WIDTH-1:0] w_aExt;
  logic [MAX_WIDTH-1:0] w_bExt;
  logic [WIDTH-1:0]     w_aMag;
  logic [WIDTH-1:0]     w_bMag;
  logic [2*WIDTH-1:0]   w_addend;
  logic                 w_lastIter;

  // Operands are multiplied as magnitudes; the sign is reapplied once at the end.
  assign w_aExt     = signed_mode ? MAX_WIDTH'(signed'(a)) : MAX_WIDTH'(a);
  assign w_bExt     = signed_mode ? MAX_WIDTH'(signed'(b)) : MAX_WIDTH'(b);
  assign w_aMag     = WIDTH'(abs_twos(w_aExt, signed_mode));
  assign w_bMag     = WIDTH'(abs_twos(w_bExt, signed_mode));
  assign w_addend   = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= w_aMag;
            r_mplier <= w_bMag;
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_lastIter) begin
            r_state <= ST_FINISH;
          end
        end
        // Busy stays high through the done cycle and drops at the following edge.
        ST_FINISH: begin
          r_result <= r_neg ? -r_acc : r_acc;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
